// File: rtl/nonseq_counter_pkg.sv
// Shared constants for the non-sequential display counter: code table and divider sizing.
// Pure definitions, no logic; latency/backpressure not applicable.
package nonseq_counter_pkg;

    // Entry i is packed at bits [4*i+3:4*i]; element 0 is the first code shown after reset.
    localparam logic [15:0][3:0] SEQ_TABLE = {
        4'd15, 4'd13, 4'd11, 4'd10, 4'd8, 4'd6, 4'd4, 4'd1,
        4'd12, 4'd7,  4'd2,  4'd14, 4'd9, 4'd5, 4'd3, 4'd0
    };

    function automatic int calc_tick_div(input int clk_hz, input int step_hz);
        return clk_hz / step_hz;
    endfunction

endpackage

// File: rtl/nonseq_counter_core_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
// Press asserts DEBOUNCE_CYCLES cycles after the synchronized input settles; no backpressure.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;
    logic             differ;
    logic             settled;

    assign differ  = (sync_q2 != btn_level);
    assign settled = differ && (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    // Press is raised in the cycle whose closing edge flips the debounced level.
    assign btn_press = settled & sync_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            stable_cnt <= '0;
            btn_level  <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            if (!differ || settled) begin
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if (settled) begin
                btn_level <= sync_q2;
            end
        end
    end

endmodule

// File: rtl/nonseq_counter_core.sv
// Steps a 4-bit code through a fixed table on a divided tick (run) or a debounced button (paused).
// value/index update on the step edge itself; wrap pulses one cycle on boundary crossings; no backpressure.
module nonseq_counter_core
    import nonseq_counter_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int STEP_HZ         = 1,
    parameter int SEQ_LEN         = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       dir,
    input  logic       step_btn,
    output logic [3:0] value,
    output logic [3:0] index,
    output logic       wrap
);

    localparam int         TICK_DIV = calc_tick_div(CLK_HZ, STEP_HZ);
    localparam int         DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             press;
    logic             btn_level_unused;
    logic             step;
    logic [3:0]       next_idx;
    logic             crossed;

    assign tick = run && (div_cnt == DIV_W'(TICK_DIV - 1));

    // Dropping run clears the count so a resumed run always waits a full period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (!run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (step_btn),
        .btn_level(btn_level_unused),
        .btn_press(press)
    );

    // Presses while running are dropped, not deferred.
    assign step = tick | (~run & press);

    always_comb begin
        next_idx = index;
        crossed  = 1'b0;
        if (dir) begin
            if (index == 4'd0) begin
                next_idx = LAST_IDX;
                crossed  = 1'b1;
            end else begin
                next_idx = index - 4'd1;
            end
        end else begin
            if (index == LAST_IDX) begin
                next_idx = 4'd0;
                crossed  = 1'b1;
            end else begin
                next_idx = index + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index <= 4'd0;
            value <= SEQ_TABLE[0];
            wrap  <= 1'b0;
        end else begin
            wrap <= step & crossed;
            if (step) begin
                index <= next_idx;
                value <= SEQ_TABLE[next_idx];
            end
        end
    end

endmodule

// File: tb/tb_nonseq_counter_core.sv
// Scoreboard bench for nonseq_counter_core: expected steps are queued with their cycle
// number as stimulus is applied, then matched against each observed index change.
module tb_nonseq_counter_core;

    localparam int SEQ_LEN = 8;

    typedef struct {
        int at;
        int idx;
        int val;
        int wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       step_btn = 1'b0;
    logic [3:0] value;
    logic [3:0] index;
    logic       wrap;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_idx = 0;
    int   base = 0;
    bit   mon_en = 1'b0;
    logic [3:0] prev_idx = 4'd0;
    exp_t sb[$];
    int   tb_seq[16] = '{0, 3, 5, 9, 14, 2, 7, 12, 1, 4, 6, 8, 10, 11, 13, 15};

    nonseq_counter_core #(
        .CLK_HZ         (20),
        .STEP_HZ        (2),
        .SEQ_LEN        (SEQ_LEN),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .dir     (dir),
        .step_btn(step_btn),
        .value   (value),
        .index   (index),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_step(input int at, input bit rev);
        exp_t e;
        int   nxt;
        bit   w;
        if (rev) begin
            w   = (exp_idx == 0);
            nxt = w ? SEQ_LEN - 1 : exp_idx - 1;
        end else begin
            w   = (exp_idx == SEQ_LEN - 1);
            nxt = w ? 0 : exp_idx + 1;
        end
        e.at   = at;
        e.idx  = nxt;
        e.val  = tb_seq[nxt];
        e.wrap = w;
        sb.push_back(e);
        exp_idx = nxt;
    endtask

    task automatic do_reset(input int n, input string tag);
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_rst_index"}, index, 0);
        chk({tag, "_rst_value"}, value, tb_seq[0]);
        chk({tag, "_rst_wrap"}, wrap, 0);
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        exp_idx = 0;
        base    = cyc;
        mon_en  = 1'b1;
    endtask

    // Every index change is a step; it must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_idx = index;
        end else if (mon_en) begin
            if (index !== prev_idx) begin
                if (sb.size() == 0) begin
                    chk("extra_step", index, prev_idx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("step_cycle", cyc, e.at);
                    chk("step_index", index, e.idx);
                    chk("step_value", value, e.val);
                    chk("step_wrap", wrap, e.wrap);
                end
            end else if (wrap) begin
                chk("stray_wrap", wrap, 0);
            end
            prev_idx = index;
        end
    end

    initial begin
        int s;
        int t;
        int r;

        @(posedge clk);
        #1;

        // Forward auto-run: full pass, wrap only on 12->0.
        run = 1'b1;
        dir = 1'b0;
        do_reset(3, "fwd");
        for (int k = 1; k <= 8; k++) expect_step(base + 10 * k, 1'b0);
        wait_cyc(85);
        chk("sb_empty_fwd", sb.size(), 0);

        // Reverse from reset: 0 -> 7 wraps, then 7 -> 6.
        dir = 1'b1;
        do_reset(2, "rev");
        expect_step(base + 10, 1'b1);
        expect_step(base + 20, 1'b1);
        wait_cyc(25);
        chk("sb_empty_rev", sb.size(), 0);

        // Paused: bouncy press yields one step 6 cycles after settling.
        run = 1'b0;
        dir = 1'b0;
        do_reset(2, "btn");
        wait_cyc(2);
        for (int k = 0; k < 4; k++) begin
            step_btn = (k % 2 == 0);
            wait_cyc(1);
        end
        step_btn = 1'b1;
        s = cyc;
        expect_step(s + 6, 1'b0);
        wait_cyc(20);
        step_btn = 1'b0;
        wait_cyc(15);
        chk("sb_empty_btn", sb.size(), 0);
        chk("btn_value_hold", value, 3);

        // Short pulses are rejected; a press while running is discarded.
        for (int k = 0; k < 3; k++) begin
            step_btn = 1'b1;
            wait_cyc(3);
            step_btn = 1'b0;
            wait_cyc(3);
        end
        chk("sb_empty_glitch", sb.size(), 0);
        chk("glitch_index", index, 1);
        run      = 1'b1;
        step_btn = 1'b1;
        t = cyc;
        for (int k = 1; k <= 3; k++) expect_step(t + 10 * k, 1'b0);
        wait_cyc(20);
        step_btn = 1'b0;
        wait_cyc(15);
        run = 1'b0;
        wait_cyc(5);
        chk("sb_empty_runbtn", sb.size(), 0);

        // Run dropped at count 7 discards the partial period.
        run = 1'b1;
        dir = 1'b0;
        do_reset(2, "pause");
        wait_cyc(7);
        run = 1'b0;
        wait_cyc(3);
        run = 1'b1;
        r = cyc;
        for (int k = 1; k <= 5; k++) expect_step(r + 10 * k, 1'b0);
        wait_cyc(54);
        chk("sb_empty_pause", sb.size(), 0);
        chk("pre_reset_index", index, 5);

        // One-cycle reset mid-period at index 5, then full periods again.
        do_reset(1, "mid");
        expect_step(base + 10, 1'b0);
        expect_step(base + 20, 1'b0);
        wait_cyc(25);
        chk("sb_empty_mid", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
